fmul_pipe: RTL and testbench



---
 rtl/fmul_pkg.sv | 47 ++++
 rtl/fmul_pipe_if.sv | 40 ++++
 rtl/fmul_norm_round.sv | 64 ++++++
 rtl/fmul_pipe.sv | 103 ++++++++++
 tb/tb_fmul_pipe.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmul_pkg.sv
//------------------------------------------------------------------------------
// Module   : fmul_pkg
// Purpose  : Shared types, build widths and helpers for the fmul pipeline.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fmul_pkg;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_t;

    // Build widths; the stage payload structs below are sized from these.
    localparam int EXP_W_CFG = 4;
    localparam int MAN_W_CFG = 3;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_max_of(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    typedef struct packed {
        logic                 sign;
        logic                 zero;
        rnd_mode_t            rnd;
        logic [EXP_W_CFG-1:0] exp_a;
        logic [EXP_W_CFG-1:0] exp_b;
        logic [MAN_W_CFG:0]   sig_a;
        logic [MAN_W_CFG:0]   sig_b;
    } s1_payload_t;

    typedef struct packed {
        logic                          sign;
        logic                          zero;
        rnd_mode_t                     rnd;
        logic signed [EXP_W_CFG+1:0]   exp_sum;
        logic [2*(MAN_W_CFG+1)-1:0]    prod;
    } s2_payload_t;

endpackage

`default_nettype wire

// File: rtl/fmul_pipe_if.sv
//------------------------------------------------------------------------------
// Module   : fmul_pipe_if
// Purpose  : Operand-in / result-out stream handshake bundle for fmul_pipe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fmul_pipe_if
    import fmul_pkg::*;
#(
    parameter int EXP_W = EXP_W_CFG,
    parameter int MAN_W = MAN_W_CFG
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_rnd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_ovf;
    logic         out_unf;

    // master: operand source plus result consumer
    modport master (
        output in_valid, in_a, in_b, in_rnd, out_ready,
        input  in_ready, out_valid, out_res, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_rnd, out_ready,
        output in_ready, out_valid, out_res, out_ovf, out_unf
    );

endinterface

`default_nettype wire

// File: rtl/fmul_norm_round.sv
//------------------------------------------------------------------------------
// Module   : fmul_norm_round
// Purpose  : Combinational normalise, round, range-check and pack of a raw product.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fmul_norm_round
    import fmul_pkg::*;
#(
    parameter int EXP_W = EXP_W_CFG,
    parameter int MAN_W = MAN_W_CFG
) (
    input  wire logic                       i_sign,
    input  wire logic                       i_zero,
    input  wire rnd_mode_t                  i_rnd,
    input  wire logic signed [EXP_W+1:0]    i_exp_sum,
    input  wire logic [2*(MAN_W+1)-1:0]     i_prod,
    output logic [EXP_W+MAN_W:0]            o_res,
    output logic                            o_ovf,
    output logic                            o_unf
);
    localparam int PW = 2 * (MAN_W + 1);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] C_EXP_MAX = EW'(exp_max_of(EXP_W));
    localparam logic signed [EW-1:0] C_EXP_MIN = EW'(1);
    localparam logic [MAN_W:0]       C_HALF    = {1'b1, {MAN_W{1'b0}}};

    logic                 w_norm;
    logic [MAN_W-1:0]     w_man;
    logic [MAN_W:0]       w_rem;
    logic                 w_round_up;
    logic [MAN_W:0]       w_man_inc;
    logic signed [EW-1:0] w_exp_fin;

    // Product lies in [1,4); the MSB says whether it reached [2,4).
    assign w_norm = i_prod[PW-1];
    assign w_man  = w_norm ? i_prod[PW-2 -: MAN_W] : i_prod[PW-3 -: MAN_W];
    assign w_rem  = w_norm ? i_prod[MAN_W:0] : {i_prod[MAN_W-1:0], 1'b0};

    assign w_round_up = (i_rnd == RND_RNE) &&
                        ((w_rem > C_HALF) || ((w_rem == C_HALF) && w_man[0]));
    assign w_man_inc  = {1'b0, w_man} + (MAN_W+1)'(w_round_up);
    // A carry out leaves the low mantissa bits at zero, matching 1.0 x 2^(e+1).
    assign w_exp_fin  = i_exp_sum + EW'(w_norm) + EW'(w_man_inc[MAN_W]);

    always_comb begin
        o_res = {i_sign, w_exp_fin[EXP_W-1:0], w_man_inc[MAN_W-1:0]};
        o_ovf = 1'b0;
        o_unf = 1'b0;
        if (i_zero) begin
            o_res = {i_sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (w_exp_fin > C_EXP_MAX) begin
            o_res = {i_sign, {(EXP_W+MAN_W){1'b1}}};
            o_ovf = 1'b1;
        end else if (w_exp_fin < C_EXP_MIN) begin
            o_res = {i_sign, {(EXP_W+MAN_W){1'b0}}};
            o_unf = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fmul_pipe.sv
//------------------------------------------------------------------------------
// Module   : fmul_pipe
// Purpose  : 3-stage floating-point multiplier with valid/ready stream handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fmul_pipe
    import fmul_pkg::*;
#(
    parameter int EXP_W = EXP_W_CFG,
    parameter int MAN_W = MAN_W_CFG
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    fmul_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic [EW-1:0] C_BIAS = EW'(bias_of(EXP_W));

    logic         w_en;
    s1_payload_t  w_s1_next;
    s1_payload_t  r_s1;
    logic         r_s1_valid;
    s2_payload_t  w_s2_next;
    s2_payload_t  r_s2;
    logic         r_s2_valid;
    logic         r_out_valid;
    logic [W-1:0] r_out_res;
    logic         r_out_ovf;
    logic         r_out_unf;
    logic [W-1:0] w_res;
    logic         w_ovf;
    logic         w_unf;

    // One global enable: the whole pipe advances only when the output slot frees.
    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    always_comb begin
        w_s1_next.sign  = bus.in_a[W-1] ^ bus.in_b[W-1];
        w_s1_next.zero  = (bus.in_a[W-2 -: EXP_W] == '0) || (bus.in_b[W-2 -: EXP_W] == '0);
        w_s1_next.rnd   = rnd_mode_t'(bus.in_rnd);
        w_s1_next.exp_a = bus.in_a[W-2 -: EXP_W];
        w_s1_next.exp_b = bus.in_b[W-2 -: EXP_W];
        w_s1_next.sig_a = {1'b1, bus.in_a[MAN_W-1:0]};
        w_s1_next.sig_b = {1'b1, bus.in_b[MAN_W-1:0]};
    end

    always_comb begin
        w_s2_next.sign    = r_s1.sign;
        w_s2_next.zero    = r_s1.zero;
        w_s2_next.rnd     = r_s1.rnd;
        w_s2_next.exp_sum = EW'(r_s1.exp_a) + EW'(r_s1.exp_b) - C_BIAS;
        w_s2_next.prod    = PW'(r_s1.sig_a) * PW'(r_s1.sig_b);
    end

    fmul_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .i_sign    (r_s2.sign),
        .i_zero    (r_s2.zero),
        .i_rnd     (r_s2.rnd),
        .i_exp_sum (r_s2.exp_sum),
        .i_prod    (r_s2.prod),
        .o_res     (w_res),
        .o_ovf     (w_ovf),
        .o_unf     (w_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_s2_valid  <= 1'b0;
            r_s2        <= '0;
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_s1        <= w_s1_next;
            r_s2_valid  <= r_s1_valid;
            r_s2        <= w_s2_next;
            r_out_valid <= r_s2_valid;
            r_out_res   <= w_res;
            r_out_ovf   <= w_ovf;
            r_out_unf   <= w_unf;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_res   = r_out_res;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_unf   = r_out_unf;

endmodule

`default_nettype wire

// File: tb/tb_fmul_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_fmul_pipe
// Purpose  : Self-checking bench for fmul_pipe against an arithmetic reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fmul_pipe;
    localparam int EXP_W   = 4;
    localparam int MAN_W   = 3;
    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int BIAS    = 7;
    localparam int EXP_MAX = 15;
    localparam int N_RAND  = 300;
    localparam int N_DIR   = 10;

    typedef struct packed {
        logic         ovf;
        logic         unf;
        logic [W-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fmul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks    = 0;
    int   errors    = 0;
    int   out_count = 0;
    exp_t q[$];
    logic rand_bp   = 1'b0;
    logic prev_stall = 1'b0;
    exp_t prev_out;

    // Directed vectors with hand-derived results.
    logic [W-1:0] d_a   [N_DIR] = '{8'h3C, 8'h3D, 8'h3D, 8'h39, 8'h39, 8'h3C, 8'h7F, 8'hFF, 8'h08, 8'h80};
    logic [W-1:0] d_b   [N_DIR] = '{8'h3C, 8'h3D, 8'h3D, 8'h3E, 8'h3E, 8'h3E, 8'h7F, 8'h7F, 8'h08, 8'h3C};
    logic         d_rnd [N_DIR] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
    logic [W-1:0] d_res [N_DIR] = '{8'h41, 8'h43, 8'h42, 8'h40, 8'h3F, 8'h42, 8'h7F, 8'hFF, 8'h00, 8'h80};
    logic         d_ovf [N_DIR] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    logic         d_unf [N_DIR] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

    // Exact integer product, then find the leading one and round the tail.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic rnd);
        exp_t r;
        int s, ea, eb, p, k, sh, m, rem, e;
        s  = int'(a[W-1] ^ b[W-1]);
        ea = int'(a[W-2 -: EXP_W]);
        eb = int'(b[W-2 -: EXP_W]);
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.res = W'(s << (W-1));
        if (ea == 0 || eb == 0) return r;
        p = ((1 << MAN_W) + int'(a[MAN_W-1:0])) * ((1 << MAN_W) + int'(b[MAN_W-1:0]));
        k = 0;
        for (int i = 0; i < 31; i++) if (((p >> i) & 1) == 1) k = i;
        sh  = k - MAN_W;
        m   = p >> sh;
        rem = p - (m << sh);
        e   = ea + eb - BIAS - 2 * MAN_W + k;
        if (rnd && ((2 * rem > (1 << sh)) || ((2 * rem == (1 << sh)) && (m % 2 == 1)))) m++;
        if (m == (1 << (MAN_W + 1))) begin
            m = m >> 1;
            e++;
        end
        if (e > EXP_MAX) begin
            r.ovf = 1'b1;
            r.res = r.res | W'((EXP_MAX << MAN_W) | ((1 << MAN_W) - 1));
        end else if (e < 1) begin
            r.unf = 1'b1;
        end else begin
            r.res = r.res | W'((e << MAN_W) | (m & ((1 << MAN_W) - 1)));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: push on accepted inputs, pop and compare on accepted outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'({bus.out_ovf, bus.out_unf, bus.out_res}), 32'(prev_out));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got result %0h expected no output at %0t", bus.out_res, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks--;
                    check("stream_res", 32'(bus.out_res), 32'(e.res));
                    check("stream_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                    check("stream_unf", 32'(bus.out_unf), 32'(e.unf));
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_a, bus.in_b, bus.in_rnd));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = '{ovf: bus.out_ovf, unf: bus.out_unf, res: bus.out_res};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic rnd);
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rnd   = rnd;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_one(input int i);
        int  lat;
        send(d_a[i], d_b[i], d_rnd[i]);
        lat = 1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) break;
        end
        check("latency", 32'(lat), 32'd3);
        check("dir_res", 32'(bus.out_res), 32'(d_res[i]));
        check("dir_ovf", 32'(bus.out_ovf), 32'(d_ovf[i]));
        check("dir_unf", 32'(bus.out_unf), 32'(d_unf[i]));
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [EXP_W-1:0] e;
        e = ($urandom_range(0, 7) == 0) ? '0 : EXP_W'($urandom_range(1, EXP_MAX));
        return {1'($urandom_range(0, 1)), e, MAN_W'($urandom_range(0, (1 << MAN_W) - 1))};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bp_idx;
        logic acc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_rnd    = 1'b0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < N_DIR; i++)
            check("model_pin", 32'(model(d_a[i], d_b[i], d_rnd[i])), 32'({d_ovf[i], d_unf[i], d_res[i]}));

        repeat (3) @(posedge clk);
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res", 32'(bus.out_res), 32'd0);
        check("rst_flags", 32'({bus.out_ovf, bus.out_unf}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < N_DIR; i++) run_one(i);

        // Randomized stream with random gaps and random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < N_RAND; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);

        // Backpressure: five pairs against a stalled consumer.
        repeat (3) @(posedge clk);
        #1;
        base = out_count;
        bus.out_ready = 1'b0;
        bp_idx = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a = d_a[bp_idx];
            bus.in_b = d_b[bp_idx];
            bus.in_rnd = d_rnd[bp_idx];
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) bp_idx++;
        end
        check("bp_accepted", 32'(bp_idx), 32'd3);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && bp_idx < 5; c++) begin
            bus.in_a = d_a[bp_idx];
            bus.in_b = d_b[bp_idx];
            bus.in_rnd = d_rnd[bp_idx];
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) bp_idx++;
        end
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp_out_count", 32'(out_count - base), 32'd5);

        // Asynchronous reset with two pairs in flight.
        bus.out_ready = 1'b0;
        send(8'h3C, 8'h3C, 1'b1);
        send(8'h3D, 8'h3D, 1'b1);
        @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        base = out_count;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_res", 32'(bus.out_res), 32'd0);
        check("arst_flags", 32'({bus.out_ovf, bus.out_unf}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_output", 32'(out_count - base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
